// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: default LCD timing, init nibbles, sequencer state encodings and gap decode
package lcd_timing_pkg;
    localparam int CNT_W = 20;
    localparam int STB_W = 8;
    localparam int DEF_T_POWERUP = 750000;
    localparam int DEF_T_SETUP = 2;
    localparam int DEF_T_PULSE = 12;
    localparam int DEF_T_HOLD = 1;
    localparam int DEF_T_NIBBLE_GAP = 50;
    localparam int DEF_T_BYTE_GAP = 2000;
    localparam int DEF_T_CLEAR_GAP = 82000;
    localparam int DEF_T_INIT1 = 205000;
    localparam int DEF_T_INIT2 = 5000;
    typedef logic [CNT_W-1:0] count_t;
    typedef enum logic [2:0] {POWERUP, INIT_NIB, INIT_WAIT, IDLE, BYTE_HI, NIB_GAP, BYTE_LO, BYTE_GAP} seqState_t;
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD} strobePhase_t;
    function automatic logic [3:0] initNibble(input logic [1:0] idx);
        return (idx == 2'd3) ? 4'h2 : 4'h3;
    endfunction
    // clear (0x01) and home (0x02/0x03) need the long execution wait
    function automatic logic isLongGap(input logic [7:0] b, input logic rs);
        return !rs && b[7:2] == 6'd0 && b != 8'd0;
    endfunction
endpackage

// File: rtl/lcd_write_sequencer_if.sv
// lcd_write_sequencer_if: byte request handshake between the text logic and the LCD sequencer
interface lcd_write_sequencer_if;
    logic       iByte_Valid;
    logic [7:0] iByte;
    logic       iByte_RS;
    logic       oByte_Ready;
    modport master (output iByte_Valid, iByte, iByte_RS, input oByte_Ready);
    modport slave (input iByte_Valid, iByte, iByte_RS, output oByte_Ready);
endinterface

// File: rtl/lcd_nibble_strobe.sv
// lcd_nibble_strobe: puts one nibble on the LCD bus with setup, E pulse and hold phases
module lcd_nibble_strobe
    import lcd_timing_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD = DEF_T_HOLD
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcdE,
    output logic       lcdRs,
    output logic [3:0] lcdData,
    output logic       done
);
    strobePhase_t phase;
    logic [STB_W-1:0] count;
    assign done = phase == PH_HOLD && count == '0;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase <= PH_IDLE;
            count <= '0;
            lcdE <= 1'b0;
            lcdRs <= 1'b0;
            lcdData <= '0;
        end else if (start) begin
            phase <= PH_SETUP;
            count <= STB_W'(T_SETUP - 1);
            lcdE <= 1'b0;
            lcdRs <= rs;
            lcdData <= nibble;
        end else if (phase != PH_IDLE) begin
            if (count != '0) count <= count - STB_W'(1);
            else begin
                phase <= (phase == PH_SETUP) ? PH_PULSE : (phase == PH_PULSE) ? PH_HOLD : PH_IDLE;
                count <= (phase == PH_SETUP) ? STB_W'(T_PULSE - 1) : STB_W'(T_HOLD - 1);
                lcdE <= phase == PH_SETUP;
            end
        end
    end
endmodule

// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: runs LCD power-on init, then writes handshaked bytes as two timed nibbles
module lcd_write_sequencer
    import lcd_timing_pkg::*;
#(
    parameter int T_POWERUP = DEF_T_POWERUP,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_PULSE = DEF_T_PULSE,
    parameter int T_HOLD = DEF_T_HOLD,
    parameter int T_NIBBLE_GAP = DEF_T_NIBBLE_GAP,
    parameter int T_BYTE_GAP = DEF_T_BYTE_GAP,
    parameter int T_CLEAR_GAP = DEF_T_CLEAR_GAP,
    parameter int T_INIT1 = DEF_T_INIT1,
    parameter int T_INIT2 = DEF_T_INIT2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    lcd_write_sequencer_if.slave  byteIf,
    output logic                  oInit_Done,
    output logic                  oLCD_Enabled,
    output logic                  oLCD_RegisterSelect,
    output logic                  oLCD_StrataFlashControl,
    output logic                  oLCD_ReadWrite,
    output logic [3:0]            oLCD_Data
);
    localparam count_t POWERUP_LAST = count_t'(T_POWERUP - 1);
    seqState_t state;
    count_t count, initWaitLoad, byteGapLoad;
    logic [1:0] initIdx;
    logic [7:0] byteReg;
    logic rsReg, readyReg, xfer, launch, launchRs, strobeDone;
    logic [3:0] launchNib;
    assign byteIf.oByte_Ready = readyReg;
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite = 1'b0;
    assign xfer = byteIf.iByte_Valid && readyReg;
    always_comb begin
        launch = (state == POWERUP && count == POWERUP_LAST) || (state == INIT_WAIT && count == '0 && initIdx != 2'd3) || xfer || (state == NIB_GAP && count == '0);
        launchNib = (state == POWERUP) ? initNibble(2'd0) : (state == INIT_WAIT) ? initNibble(initIdx + 2'd1) : (state == IDLE) ? byteIf.iByte[7:4] : byteReg[3:0];
        launchRs = (state == IDLE) ? byteIf.iByte_RS : (state == NIB_GAP) && rsReg;
        initWaitLoad = (initIdx == 2'd0) ? count_t'(T_INIT1 - 1) : (initIdx == 2'd1) ? count_t'(T_INIT2 - 1) : count_t'(T_BYTE_GAP - 1);
        byteGapLoad = isLongGap(byteReg, rsReg) ? count_t'(T_CLEAR_GAP - 1) : count_t'(T_BYTE_GAP - 1);
    end
    lcd_nibble_strobe #(.T_SETUP(T_SETUP), .T_PULSE(T_PULSE), .T_HOLD(T_HOLD)) strobe (
        .Clock(Clock), .Reset(Reset), .start(launch), .nibble(launchNib), .rs(launchRs),
        .lcdE(oLCD_Enabled), .lcdRs(oLCD_RegisterSelect), .lcdData(oLCD_Data), .done(strobeDone)
    );
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= POWERUP;
            count <= '0;
            initIdx <= '0;
            byteReg <= '0;
            rsReg <= 1'b0;
            readyReg <= 1'b0;
            oInit_Done <= 1'b0;
        end else begin
            case (state)
                // reset leaves the counter at 0, so the power-up wait counts up instead
                POWERUP: begin
                    count <= (count == POWERUP_LAST) ? '0 : count + count_t'(1);
                    if (count == POWERUP_LAST) state <= INIT_NIB;
                end
                INIT_NIB: if (strobeDone) begin
                    state <= INIT_WAIT;
                    count <= initWaitLoad;
                end
                INIT_WAIT: if (count != '0) count <= count - count_t'(1);
                    else if (initIdx == 2'd3) begin
                        state <= IDLE;
                        readyReg <= 1'b1;
                        oInit_Done <= 1'b1;
                    end else begin
                        state <= INIT_NIB;
                        initIdx <= initIdx + 2'd1;
                    end
                IDLE: if (xfer) begin
                    byteReg <= byteIf.iByte;
                    rsReg <= byteIf.iByte_RS;
                    readyReg <= 1'b0;
                    state <= BYTE_HI;
                end
                BYTE_HI: if (strobeDone) begin
                    state <= NIB_GAP;
                    count <= count_t'(T_NIBBLE_GAP - 1);
                end
                NIB_GAP: if (count != '0) count <= count - count_t'(1);
                    else state <= BYTE_LO;
                BYTE_LO: if (strobeDone) begin
                    state <= BYTE_GAP;
                    count <= byteGapLoad;
                end
                BYTE_GAP: if (count != '0) count <= count - count_t'(1);
                    else begin
                        state <= IDLE;
                        readyReg <= 1'b1;
                    end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb_lcd_write_sequencer: scoreboard bench for init sequencing, nibble strobes, gap timing and reset abort
module tb_lcd_write_sequencer;
    typedef struct packed { logic [3:0] nib; logic rs; } nib_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic initDone, lcdE, lcdRs, sfCe, lcdRw;
    logic [3:0] lcdData;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int pulses = 0;
    nib_t expQ[$];
    int riseEdge[$];
    logic monPrevE = 1'b0;
    logic monGlitch = 1'b0;
    nib_t monH1 = '0, monH2 = '0, monCur = '0, monPulse = '0, monExp = '0;
    int monWidth = 0;
    logic [7:0] vecByte [7] = '{8'h41, 8'h01, 8'h80, 8'h03, 8'h04, 8'h02, 8'h00};
    logic       vecRs   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int         vecBusy [7] = '{45, 95, 45, 95, 45, 45, 45};
    int         initRise [4] = '{102, 157, 192, 217};

    lcd_write_sequencer_if bIf();
    lcd_write_sequencer #(
        .T_POWERUP(100), .T_SETUP(2), .T_PULSE(12), .T_HOLD(1), .T_NIBBLE_GAP(5),
        .T_BYTE_GAP(10), .T_CLEAR_GAP(60), .T_INIT1(40), .T_INIT2(20)
    ) dut (
        .Clock(clk), .Reset(rst), .byteIf(bIf.slave), .oInit_Done(initDone),
        .oLCD_Enabled(lcdE), .oLCD_RegisterSelect(lcdRs), .oLCD_StrataFlashControl(sfCe),
        .oLCD_ReadWrite(lcdRw), .oLCD_Data(lcdData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, req, cyc);
        end
    endtask

    // monitor: every E pulse is timed and matched against the scoreboard queue
    initial forever begin
        @(negedge clk);
        monCur = {lcdData, lcdRs};
        if (rst) begin
            monPrevE = 1'b0;
            monWidth = 0;
        end else begin
            if (lcdE && !monPrevE) begin
                riseEdge.push_back(cyc);
                check("setup stable", {monH2, monH1}, {monCur, monCur});
                monPulse = monCur;
                monWidth = 0;
                monGlitch = 1'b0;
            end
            if (lcdE) begin
                monWidth++;
                if (monCur != monPulse) monGlitch = 1'b1;
            end
            if (!lcdE && monPrevE) begin
                pulses++;
                check("E high width", monWidth, 12);
                check("data stable in pulse", monGlitch, 0);
                check("hold data", monCur, monPulse);
                if (expQ.size() == 0) check("unexpected pulse", monPulse, -1);
                else begin
                    monExp = expQ.pop_front();
                    check("nibble/rs", monPulse, monExp);
                end
            end
            monPrevE = lcdE;
        end
        monH2 = monH1;
        monH1 = monCur;
    end

    task automatic waitReady(output int edgeSeen);
        edgeSeen = -1;
        for (int i = 0; i < 2000 && edgeSeen < 0; i++) begin
            if (bIf.oByte_Ready) edgeSeen = cyc;
            else @(negedge clk);
        end
        if (edgeSeen < 0) check("ready timeout", 0, 1);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic r, output int k);
        k = -1;
        bIf.iByte_Valid = 1'b1;
        bIf.iByte = b;
        bIf.iByte_RS = r;
        for (int i = 0; i < 2000 && k < 0; i++) begin
            if (bIf.oByte_Ready) k = cyc + 1;
            @(negedge clk);
        end
        if (k < 0) check("transfer timeout", 0, 1);
        else begin
            expQ.push_back({b[7:4], r});
            expQ.push_back({b[3:0], r});
            check("ready low after transfer", bIf.oByte_Ready, 0);
        end
    endtask

    task automatic runInit();
        int rel;
        int doneEdge = -1;
        logic early = 1'b0;
        expQ.delete();
        riseEdge.delete();
        for (int i = 0; i < 4; i++) expQ.push_back({(i == 3) ? 4'h2 : 4'h3, 1'b0});
        rst = 1'b0;
        rel = cyc;
        for (int i = 0; i < 1000 && doneEdge < 0; i++) begin
            @(negedge clk);
            if (initDone) doneEdge = cyc;
            else if (bIf.oByte_Ready) early = 1'b1;
        end
        check("ready before init done", early, 0);
        check("init done edge", doneEdge - rel, 240);
        check("ready at init done", bIf.oByte_Ready, 1);
        check("init pulse count", riseEdge.size(), 4);
        for (int i = 0; i < 4 && i < riseEdge.size(); i++) check($sformatf("init rise %0d", i), riseEdge[i] - rel, initRise[i]);
        check("init queue drained", expQ.size(), 0);
    endtask

    initial begin
        int k, k2, k3, e, p0;
        bIf.iByte_Valid = 1'b0;
        bIf.iByte = '0;
        bIf.iByte_RS = 1'b0;
        repeat (5) @(negedge clk);
        check("reset E", lcdE, 0);
        check("reset RS", lcdRs, 0);
        check("reset RW", lcdRw, 0);
        check("reset SF_CE", sfCe, 1);
        check("reset data", lcdData, 0);
        check("reset ready", bIf.oByte_Ready, 0);
        check("reset init done", initDone, 0);
        runInit();
        for (int i = 0; i < 7; i++) begin
            sendByte(vecByte[i], vecRs[i], k);
            bIf.iByte_Valid = 1'b0;
            waitReady(e);
            check($sformatf("busy byte %0d", i), e - k, vecBusy[i]);
        end
        p0 = pulses;
        sendByte(8'h48, 1'b1, k);
        sendByte(8'h69, 1'b1, k2);
        sendByte(8'h10, 1'b0, k3);
        bIf.iByte_Valid = 1'b0;
        waitReady(e);
        check("back-to-back spacing 1", k2 - k, 46);
        check("back-to-back spacing 2", k3 - k2, 46);
        check("back-to-back last busy", e - k3, 45);
        check("back-to-back pulses", pulses - p0, 6);
        check("back-to-back queue drained", expQ.size(), 0);
        sendByte(8'h55, 1'b1, k);
        bIf.iByte_Valid = 1'b0;
        while (cyc < k + 25) @(negedge clk);
        check("E high in low nibble", lcdE, 1);
        check("low nibble on bus", lcdData, 5);
        rst = 1'b1;
        @(negedge clk);
        check("abort E", lcdE, 0);
        check("abort ready", bIf.oByte_Ready, 0);
        check("abort init done", initDone, 0);
        check("abort SF_CE", sfCe, 1);
        repeat (2) @(negedge clk);
        runInit();
        sendByte(8'h38, 1'b0, k);
        bIf.iByte_Valid = 1'b0;
        waitReady(e);
        check("busy after reinit", e - k, 45);
        check("final queue drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
